gpio_bcd_display: RTL and testbench
===================================

GPIO_BCD_DISPLAY -- requirements
Module: gpio_bcd_display

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 1: 1 means a lit segment is driven 0; 0 inverts every segment output.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 value  input  32  unsigned binary value to display; connects to the CPU gpio_out register.
REQ-005 hex  output  56  eight 7-bit segment codes; hex[7*i+6:7*i] is decimal digit i (0 = least significant); bit order gfedcba.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 overflow  output  1  high when the last converted value is >= 100_000_000.

Function
REQ-008 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-009 In IDLE, when value != last_value, the block SHALL capture value into a 32-bit shift register, clear a 42-bit BCD accumulator and a 6-bit counter, and enter SHIFT; otherwise it SHALL stay in IDLE.
REQ-010 In SHIFT, each cycle SHALL apply double-dabble: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left one bit; after 32 shifts the block SHALL enter DONE.
REQ-011 In DONE, the block SHALL load the low 8 BCD digits into the display register, set overflow = (digit9 | digit8) != 0, set last_value to the captured value, and return to IDLE.
REQ-012 busy SHALL be a registered output, high in SHIFT and DONE: exactly 33 cycles per conversion.
REQ-013 hex SHALL update exactly 33 rising edges after the edge that captured value; it SHALL never show partial or intermediate BCD.
REQ-014 Changes on value during SHIFT or DONE SHALL be ignored; IDLE then re-compares against last_value, so the display converges to the latest stable value.
REQ-015 Segment codes (active-low) SHALL be 0..9 = 40,79,24,30,19,12,02,78,00,10 (hex); blank = 7F.
REQ-016 BCD digits SHALL never exceed 9; any other nibble SHALL decode to blank.

Reset
REQ-017 On rst: state = IDLE, busy = 0, overflow = 0, last_value = 0, and the display register holds eight zero digits, all applied immediately.
REQ-018 A reset asserted during SHIFT or DONE SHALL abort the conversion with no display update; after release, a conversion starts only if value != 0.

Configuration
REQ-019 The macro GPIO_BCD_LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-020 With the macro defined, every zero digit above the most significant nonzero digit SHALL show blank; digit 0 is always shown.
REQ-021 Without the macro, all eight digits SHALL always show their decimal value, including leading zeros.

Structure
REQ-022 Package gpio_bcd_pkg SHALL hold the FSM state enum, NUM_DIGITS = 8, BCD_DIGITS = 10, SHIFT_COUNT = 32, and the SEG_* segment constants.
REQ-023 Sub-module seg7_decode SHALL implement the combinational 4-bit-to-7-segment decoder, with inputs digit and blank; it is instantiated eight times.
REQ-024 All sequential logic SHALL use a single always_ff block sensitive to posedge clk and posedge rst.

Verification
REQ-025 Reset with value = 0: busy = 0, overflow = 0, hex = 8x 40 (macro off); with the macro on, digit 0 = 40 and digits 1-7 = 7F.
REQ-026 value = 12345678: busy is high for 33 cycles; hex digits 7..0 show 1,2,3,4,5,6,7,8; overflow = 0.
REQ-027 value = FFFFFFFF (4294967295): overflow = 1; digits 7..0 show 9,4,9,6,7,2,9,5.
REQ-028 value = 5, then changed to 99 ten cycles into SHIFT: the display shows 5 first, busy re-asserts the next cycle, and the display ends at 99; no other values appear.
REQ-029 rst pulsed during SHIFT with value = 42: outputs return to reset values immediately; after release, conversion restarts and the display shows 42 after 33 cycles.
REQ-030 value = 7 with the macro on: digits 7..1 = 7F and digit 0 = 78; value = 100 shows digits 2..0 = 79, 40, 40.

Source files
------------

// File: rtl/gpio_bcd_pkg.sv
// -----------------------------------------------------------------------------
// gpio_bcd_pkg
// Shared types and constants for the GPIO BCD display block.
//   state_t      : converter FSM states (IDLE, SHIFT, DONE)
//   NUM_DIGITS   : digits shown on the display (8)
//   BCD_DIGITS   : BCD digits needed for a full 32-bit value (10)
//   SHIFT_COUNT  : double-dabble iterations per conversion (32)
//   SEG_*        : active-low gfedcba segment codes
//   dabble_adjust: add-3 correction applied to every BCD nibble before a shift
// -----------------------------------------------------------------------------
package gpio_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int NUM_DIGITS  = 8;
  localparam int BCD_DIGITS  = 10;
  localparam int SHIFT_COUNT = 32;
  localparam int BIN_W       = 32;
  localparam int BCD_W       = 42;
  localparam int CNT_W       = 6;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Any nibble >= 5 would become >= 10 after the next shift, so pre-add 3
  // to make it carry cleanly into the next decimal digit. The two spare top
  // bits never hold data for a 32-bit input and pass through unchanged.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD digit to 7-segment decoder (active-low, gfedcba).
//   digit : 4-bit BCD digit; values above 9 decode to blank
//   blank : force the digit dark (leading-zero suppression)
//   seg   : active-low segment code
// -----------------------------------------------------------------------------
module seg7_decode
  import gpio_bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/gpio_bcd_display.sv
// -----------------------------------------------------------------------------
// gpio_bcd_display
// Converts a 32-bit GPIO value to 8 decimal digits on 7-segment displays
// using a sequential double-dabble converter (33 cycles per conversion).
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   value    : binary value to display
//   hex      : 8 x 7-bit segment codes, digit i at hex[7*i+6:7*i]
//   busy     : high while a conversion is running (SHIFT and DONE)
//   overflow : last converted value needed more than 8 digits
// Parameter SEG_ACTIVE_LOW: 1 = lit segment driven 0; 0 = inverted outputs.
// Optional macro GPIO_BCD_LEADING_ZERO_BLANK_EN: blank leading zero digits.
// -----------------------------------------------------------------------------
module gpio_bcd_display
  import gpio_bcd_pkg::*;
#(
  parameter logic SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  output logic [55:0] hex,
  output logic        busy,
  output logic        overflow
);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;     // binary shift register
  logic [BIN_W-1:0]   cap_q, cap_d;     // value being converted
  logic [BIN_W-1:0]   last_q, last_d;   // last value fully displayed
  logic [BCD_W-1:0]   bcd_q, bcd_d;     // BCD accumulator
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;  // displayed BCD digits
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_adj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      cap_q   <= '0;
      last_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      cap_q   <= cap_d;
      last_q  <= last_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    cap_d   = cap_q;
    last_d  = last_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    bcd_adj = dabble_adjust(bcd_q);

    case (state_q)
      ST_IDLE: begin
        if (value != last_q) begin
          bin_d   = value;
          cap_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SHIFT_COUNT - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Display only ever loads a finished result, never intermediate BCD.
        disp_d  = bcd_q[4*NUM_DIGITS-1:0];
        ovf_d   = |bcd_q[BCD_W-1:4*NUM_DIGITS];
        last_d  = cap_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign overflow = ovf_q;

  logic [NUM_DIGITS-1:0] blank;
  logic [6:0]            seg [NUM_DIGITS];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
`ifdef GPIO_BCD_LEADING_ZERO_BLANK_EN
      // A digit is a leading zero when it and every digit above it are zero;
      // digit 0 always shows so a zero value still displays "0".
      if (gi == 0) begin : g_lsd
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = (disp_q[4*NUM_DIGITS-1:4*gi] == '0);
      end
`else
      assign blank[gi] = 1'b0;
`endif
      seg7_decode u_dec (
        .digit (disp_q[4*gi +: 4]),
        .blank (blank[gi]),
        .seg   (seg[gi])
      );
      assign hex[7*gi +: 7] = SEG_ACTIVE_LOW ? seg[gi] : ~seg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_gpio_bcd_display.sv
// -----------------------------------------------------------------------------
// tb_gpio_bcd_display
// Scoreboard bench: stimulus pushes expected display contents, a monitor
// pops and compares each time busy falls (conversion completion).
// -----------------------------------------------------------------------------
module tb_gpio_bcd_display;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic [55:0] hex;
  logic        busy;
  logic        overflow;

  gpio_bcd_display dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .hex      (hex),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [55:0] hex;
    logic        ov;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected segments from hand-written BCD digits (digit 7 in bcd[31:28]).
  function automatic logic [55:0] exp_hex(input logic [31:0] bcd);
    logic [55:0] h;
    logic        lead;
    logic        blank_it;
    logic [3:0]  n;
    h    = '0;
    lead = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      n = bcd[4*i +: 4];
      if (n != 4'd0 || i == 0) lead = 1'b0;
`ifdef GPIO_BCD_LEADING_ZERO_BLANK_EN
      blank_it = lead;
`else
      blank_it = 1'b0;
`endif
      h[7*i +: 7] = blank_it ? 7'h7F : seg_code(n);
    end
    return h;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout waiting for busy", name);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int k;
    k = 0;
    while (busy !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy !== lvl) timeout_fail(name);
  endtask

  task automatic push_exp(input logic [31:0] bcd, input logic ov, input string name);
    exp_t e;
    e.hex  = exp_hex(bcd);
    e.ov   = ov;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] v, input logic [31:0] bcd,
                      input logic ov, input string name);
    @(negedge clk);
    value = v;
    push_exp(bcd, ov, name);
    $display("send %s value=%0d", name, v);
    wait_busy(1'b1, 5, {name, "_start"});
    wait_busy(1'b0, 60, {name, "_end"});
  endtask

  // Monitor: compares a completed conversion against the scoreboard and
  // flags any display change that is not a completion.
  initial begin : monitor
    logic        busy_prev;
    int          busy_cnt;
    logic [55:0] last_hex;
    exp_t        e;
    busy_prev = 1'b0;
    busy_cnt  = 0;
    last_hex  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_prev = 1'b0;
        busy_cnt  = 0;
        last_hex  = hex;
      end else begin
        if (busy && !busy_prev) busy_cnt = 1;
        else if (busy) busy_cnt++;
        if (busy_prev && !busy) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: hex=%h with empty scoreboard", hex);
          end else begin
            e = exp_q.pop_front();
            $display("done %s hex=%h ovf=%0b busy_cycles=%0d", e.name, hex, overflow, busy_cnt);
            check({e.name, "_hex"}, 64'(hex), 64'(e.hex));
            check({e.name, "_ovf"}, 64'(overflow), 64'(e.ov));
            check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
          end
          busy_cnt = 0;
        end else if (hex !== last_hex) begin
          n_cmp++;
          n_bad++;
          $display("FAIL midconv_hex: got %h expected %h", hex, last_hex);
        end
        last_hex  = hex;
        busy_prev = busy;
      end
    end
  end

  initial begin
    rst   = 1'b1;
    value = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_hex", 64'(hex), 64'(exp_hex(32'h0)));
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_zero_busy", 64'(busy), 64'd0);
    check("idle_zero_hex", 64'(hex), 64'(exp_hex(32'h0)));

    send(32'd12345678, 32'h12345678, 1'b0, "v12345678");
    send(32'hFFFF_FFFF, 32'h94967295, 1'b1, "vFFFFFFFF");

    // Reset mid-conversion: outputs clear at once, no display update.
    @(negedge clk);
    value = 32'd42;
    push_exp(32'h42, 1'b0, "v42_after_rst");
    $display("send v42 with reset during SHIFT");
    wait_busy(1'b1, 5, "v42_start");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ovf", 64'(overflow), 64'd0);
    check("abort_hex", 64'(hex), 64'(exp_hex(32'h0)));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_busy(1'b1, 5, "v42_restart");
    wait_busy(1'b0, 60, "v42_end");

    // Change during SHIFT is ignored, then picked up right after DONE.
    @(negedge clk);
    value = 32'd5;
    push_exp(32'h5, 1'b0, "v5");
    $display("send v5 then v99 during SHIFT");
    wait_busy(1'b1, 5, "v5_start");
    repeat (10) @(negedge clk);
    value = 32'd99;
    push_exp(32'h99, 1'b0, "v99");
    wait_busy(1'b0, 60, "v5_end");
    @(negedge clk);
    check("rebusy_after_v5", 64'(busy), 64'd1);
    wait_busy(1'b0, 60, "v99_end");

    send(32'd99_999_999, 32'h99999999, 1'b0, "v99999999");
    send(32'd100_000_000, 32'h00000000, 1'b1, "v100000000");
    send(32'd7, 32'h7, 1'b0, "v7");
    send(32'd100, 32'h100, 1'b0, "v100");

    repeat (10) @(negedge clk);
    check("idle_stable_busy", 64'(busy), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
